sprite_ram_arbiter: RTL and testbench
=====================================

SPRITE_RAM_ARBITER -- requirements
Module: sprite_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, sprite RAM address width.
REQ-002 SHALL have parameter DATA_W, default 5, sprite RAM data width.
REQ-003 SHALL have parameter DEPTH, default 2500, number of valid sprite words (50x50).
REQ-004 SHALL have parameter BURST_MAX, default 50, maximum consecutive locked grants (one sprite row).
REQ-005 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports rd_req0, rd_req1  input  1 each  read request from tank renderer 0 or 1.
REQ-008 SHALL have ports rd_lock0, rd_lock1  input  1 each  request that the current grant continue as a burst.
REQ-009 SHALL have ports rd_addr0, rd_addr1  input  ADDR_W each  requested sprite address.
REQ-010 SHALL have port rd_gnt  output  2  one-hot, combinational read grant; bit i belongs to requester i.
REQ-011 SHALL have port rd_valid  output  2  one-hot, registered; read data valid for requester i.
REQ-012 SHALL have ports rd_data  output  DATA_W  returned read data, and rd_err  output  1  address-out-of-range flag qualified by rd_valid.
REQ-013 SHALL have ports wr_req  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W, and wr_ack  output  1; these form the sprite loader write port.
REQ-014 SHALL have ports ram_we  output  1, ram_write_address  output  ADDR_W, ram_read_address  output  ADDR_W, ram_data_In  output  DATA_W, and ram_data_Out  input  DATA_W; these connect to the frame RAM, which has a 1-cycle registered read.

Function
REQ-015 Grant SHALL be issued to at most one read requester per cycle; rd_gnt[i] implies rd_req_i was high in the same cycle.
REQ-016 Handshake SHALL be as follows: the requester holds rd_req_i and rd_addr_i stable until it samples rd_gnt[i]=1; the transfer occurs in that cycle.
REQ-017 Arbitration SHALL be round-robin via a 1-bit pointer rr, which names the preferred requester; when both requesters request and no lock is active, rd_gnt = one-hot(rr), and rr then flips to the non-granted requester.
REQ-018 When only one requester requests, that requester SHALL be granted regardless of rr, and rr SHALL be set to the other requester.
REQ-019 Burst lock SHALL operate as follows: if requester i is granted with rd_lock_i=1, the next cycles SHALL grant i whenever rd_req_i=1, and a burst counter SHALL increment on each locked grant.
REQ-020 A lock SHALL end when rd_lock_i=0 at a grant, when rd_req_i=0, or when the burst counter reaches BURST_MAX while the other requester is requesting; at that point the other requester SHALL be granted next and the counter cleared.
REQ-021 At BURST_MAX with the other requester idle, the lock SHALL continue and the counter SHALL saturate at BURST_MAX.
REQ-022 ram_read_address SHALL equal the granted rd_addr_i in the grant cycle and SHALL hold its previous value when no grant is issued.
REQ-023 Read latency SHALL be exactly 1 cycle: rd_valid[i]=1 in the cycle after rd_gnt[i], with rd_data = ram_data_Out.
REQ-024 An address >= DEPTH SHALL still be granted, SHALL NOT change ram_read_address, and SHALL return rd_data=0 with rd_err=1 one cycle later.
REQ-025 rd_err SHALL be 0 whenever rd_valid=0.
REQ-026 Writes SHALL be independent of reads: wr_ack = wr_req when wr_addr < DEPTH and 0 otherwise, combinationally.
REQ-027 ram_we SHALL equal wr_ack, and ram_write_address and ram_data_In SHALL pass through from wr_addr and wr_data.
REQ-028 On a simultaneous read and write to the same address, the read SHALL return the old data (read-before-write); no forwarding SHALL be applied.
REQ-029 An out-of-range write SHALL be dropped silently, with wr_ack=0 and ram_we=0.

Reset
REQ-030 While Reset=1, asynchronously: rr=0, burst counter=0, lock state cleared, rd_valid=00, rd_err=0, and rd_gnt=00.
REQ-031 While Reset=1, ram_read_address SHALL be 0 and ram_we SHALL be 0.
REQ-032 A grant issued in the cycle Reset asserts SHALL produce no rd_valid after Reset is released.
REQ-033 The first arbitration after reset release SHALL prefer requester 0.

Verification
REQ-034 Reset release, rd_req0=rd_req1=1 with no locks held for 4 cycles -> rd_gnt = 01,10,01,10; rd_valid follows 1 cycle later with the same pattern.
REQ-035 rd_req0=1, rd_lock0=1, rd_req1=1, BURST_MAX=50 -> 50 consecutive grants to 0, then rd_gnt=10; counter returns to 0.
REQ-036 rd_addr1=2500 -> rd_gnt=10, then rd_valid=10, rd_data=0, rd_err=1; ram_read_address unchanged.
REQ-037 wr_req=1, wr_addr=7, wr_data=5'h0A with rd_addr0=7 granted in the same cycle -> rd_data=old value; a read of address 7 on the next grant returns 5'h0A.
REQ-038 Reset asserted mid-burst while a grant is in flight -> all outputs 0 immediately; after release no stray rd_valid, and rd_req1 alone is granted in the first cycle.

Source files
------------

// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM arbiter: two-requester round-robin read arbitration with burst
// lock, one-cycle registered read return, and an independent loader write port.
module sprite_ram_arbiter #(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned DEPTH     = 2500,
  parameter int unsigned BURST_MAX = 50
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_req0,
  input  logic              rd_req1,
  input  logic              rd_lock0,
  input  logic              rd_lock1,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [DATA_W-1:0] ram_data_In,
  input  logic [DATA_W-1:0] ram_data_Out
);

  localparam int unsigned       CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C = CNT_W'(BURST_MAX);

  // Lock state: which requester (if any) currently holds a burst
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKED0  = 2'd1;
  localparam logic [1:0] LOCKED1  = 2'd2;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        lock_state, lock_next;
  logic              rr, rr_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              gnt_any, gnt_idx, gnt_lock, gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W-1:0] raddr_q, raddr_cur;
  logic              err_q;

  assign req      = {rd_req1, rd_req0};
  assign gnt_any  = |gnt;
  assign gnt_idx  = gnt[1];
  assign gnt_lock = gnt_idx ? rd_lock1 : rd_lock0;
  assign gnt_addr = gnt_idx ? rd_addr1 : rd_addr0;
  assign gnt_oor  = gnt_addr >= DEPTH_A;

  // Grant selection: an active lock wins unless its burst is exhausted and the
  // other side is waiting; otherwise single requester or round-robin pointer.
  always_comb begin
    gnt = '0;
    if (lock_state == LOCKED0 && req[0])
      gnt = (cnt == BURST_C && req[1]) ? 2'b10 : 2'b01;
    else if (lock_state == LOCKED1 && req[1])
      gnt = (cnt == BURST_C && req[0]) ? 2'b01 : 2'b10;
    else if (req == 2'b11)
      gnt = rr ? 2'b10 : 2'b01;
    else
      gnt = req;
  end

  // Next pointer/lock/counter; a locked grant to the same owner extends the
  // burst (saturating), a locked grant to a new owner starts a fresh burst.
  always_comb begin
    rr_next   = rr;
    lock_next = UNLOCKED;
    cnt_next  = '0;
    if (gnt_any) begin
      rr_next = ~gnt_idx;
      if (gnt_lock) begin
        lock_next = gnt_idx ? LOCKED1 : LOCKED0;
        if (lock_state == lock_next)
          cnt_next = (cnt == BURST_C) ? cnt : cnt + CNT_W'(1);
        else
          cnt_next = CNT_W'(1);
      end
    end
  end

  // Read address follows an in-range grant, otherwise holds
  always_comb begin
    raddr_cur = raddr_q;
    if (gnt_any && !gnt_oor)
      raddr_cur = gnt_addr;
  end

  // Arbitration state and read-return pipeline
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr         <= 1'b0;
      lock_state <= UNLOCKED;
      cnt        <= '0;
      rd_valid   <= '0;
      err_q      <= 1'b0;
      raddr_q    <= '0;
    end else begin
      rr         <= rr_next;
      lock_state <= lock_next;
      cnt        <= cnt_next;
      rd_valid   <= gnt;
      err_q      <= gnt_any && gnt_oor;
      raddr_q    <= raddr_cur;
    end
  end

  assign rd_gnt           = Reset ? 2'b00 : gnt;
  assign ram_read_address = Reset ? '0 : raddr_cur;
  assign rd_err           = err_q;
  assign rd_data          = err_q ? '0 : ram_data_Out;

  assign wr_ack            = !Reset && wr_req && (wr_addr < DEPTH_A);
  assign ram_we            = wr_ack;
  assign ram_write_address = wr_addr;
  assign ram_data_In       = wr_data;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Self-checking bench for sprite_ram_arbiter: vector table plus hand-built
// burst, saturation and reset sequences; read returns checked via scoreboard.
`timescale 1ns/1ps
module tb_sprite_ram_arbiter;

  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 5;
  localparam int unsigned DEPTH     = 2500;
  localparam int unsigned BURST_MAX = 50;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              rd_req0, rd_req1, rd_lock0, rd_lock1;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic [1:0]        rd_gnt, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, ram_we;
  logic [ADDR_W-1:0] ram_write_address, ram_read_address;
  logic [DATA_W-1:0] ram_data_In, ram_data_Out;

  always #5 Clk = ~Clk;

  sprite_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .rd_req0(rd_req0), .rd_req1(rd_req1),
    .rd_lock0(rd_lock0), .rd_lock1(rd_lock1),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_we(ram_we), .ram_write_address(ram_write_address),
    .ram_read_address(ram_read_address), .ram_data_In(ram_data_In),
    .ram_data_Out(ram_data_Out)
  );

  // Frame RAM: registered read, read-before-write on the same address
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge Clk) begin
    if (ram_we) mem[ram_write_address[11:0]] <= ram_data_In;
    ram_data_Out <= mem[ram_read_address[11:0]];
  end

  typedef struct {
    logic r0, r1, l0, l1;
    logic [ADDR_W-1:0] a0, a1;
    logic w;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [1:0] eg;
  } vec_t;

  typedef struct {
    logic [1:0]        valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] exp_raddr;
  int unsigned       n_checks = 0;
  int unsigned       n_pass   = 0;
  vec_t              tbl [19];

  function automatic vec_t mk(input logic r0, r1, l0, l1, input int a0, a1,
                              input logic w, input int wa, input int wd,
                              input logic [1:0] eg);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.a0 = ADDR_W'(a0); v.a1 = ADDR_W'(a1);
    v.w = w; v.wa = ADDR_W'(wa); v.wd = DATA_W'(wd);
    v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_resp();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rd_valid", 64'(rd_valid), 64'(e.valid));
      chk("rd_err", 64'(rd_err), 64'(e.err));
      if (e.valid != 2'b00) chk("rd_data", 64'(rd_data), 64'(e.data));
    end
  endtask

  task automatic push_exp(input logic [1:0] eg, input logic [ADDR_W-1:0] a0, a1);
    exp_t e;
    logic [ADDR_W-1:0] a;
    e.valid = eg; e.err = 1'b0; e.data = '0;
    if (eg != 2'b00) begin
      a = eg[1] ? a1 : a0;
      if (a >= ADDR_W'(DEPTH)) e.err = 1'b1;
      else begin
        e.data    = ref_mem[a];
        exp_raddr = a;
      end
    end
    sb.push_back(e);
  endtask

  task automatic cycle(input vec_t v);
    logic exp_ack;
    @(negedge Clk);
    check_resp();
    rd_req0 = v.r0; rd_req1 = v.r1; rd_lock0 = v.l0; rd_lock1 = v.l1;
    rd_addr0 = v.a0; rd_addr1 = v.a1;
    wr_req = v.w; wr_addr = v.wa; wr_data = v.wd;
    #1;
    chk("rd_gnt", 64'(rd_gnt), 64'(v.eg));
    push_exp(v.eg, v.a0, v.a1);
    chk("ram_read_address", 64'(ram_read_address), 64'(exp_raddr));
    exp_ack = v.w && (v.wa < ADDR_W'(DEPTH));
    chk("wr_ack", 64'(wr_ack), 64'(exp_ack));
    chk("ram_we", 64'(ram_we), 64'(exp_ack));
    if (v.w) chk("ram_wr_path", 64'({ram_write_address, ram_data_In}), 64'({v.wa, v.wd}));
    if (exp_ack) ref_mem[v.wa] = v.wd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(rd_gnt), 64'(0));
    chk({tag, "_valid"}, 64'(rd_valid), 64'(0));
    chk({tag, "_err"}, 64'(rd_err), 64'(0));
    chk({tag, "_raddr"}, 64'(ram_read_address), 64'(0));
    chk({tag, "_we"}, 64'(ram_we), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t none;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = DATA_W'(i * 3 + 1);
      ref_mem[i] = DATA_W'(i * 3 + 1);
    end
    none.valid = 2'b00; none.err = 1'b0; none.data = '0;

    // Reset held with both requesting and an in-range write pending
    Reset = 1'b1;
    rd_req0 = 1'b1; rd_req1 = 1'b1; rd_lock0 = 1'b0; rd_lock1 = 1'b0;
    rd_addr0 = ADDR_W'(3); rd_addr1 = ADDR_W'(4);
    wr_req = 1'b1; wr_addr = ADDR_W'(7); wr_data = 5'h01;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("reset");
    rd_req0 = 1'b0; rd_req1 = 1'b0; wr_req = 1'b0;
    Reset = 1'b0;
    exp_raddr = '0;

    //           r0 r1 l0 l1  a0    a1    w  wa    wd    gnt
    tbl[0]  = mk(1, 1, 0, 0,  10,   20,   0, 0,    0,    2'b01);
    tbl[1]  = mk(1, 1, 0, 0,  11,   21,   0, 0,    0,    2'b10);
    tbl[2]  = mk(1, 1, 0, 0,  12,   22,   0, 0,    0,    2'b01);
    tbl[3]  = mk(1, 1, 0, 0,  13,   23,   1, 2499, 31,   2'b10);
    tbl[4]  = mk(0, 1, 0, 0,  0,    2500, 0, 0,    0,    2'b10);
    tbl[5]  = mk(1, 0, 0, 0,  2499, 0,    0, 0,    0,    2'b01);
    tbl[6]  = mk(1, 0, 0, 0,  5,    0,    0, 0,    0,    2'b01);
    tbl[7]  = mk(1, 1, 0, 0,  6,    7,    0, 0,    0,    2'b10);
    tbl[8]  = mk(0, 0, 0, 0,  0,    0,    1, 2500, 3,    2'b00);
    tbl[9]  = mk(1, 1, 0, 1,  8,    9,    0, 0,    0,    2'b01);
    tbl[10] = mk(1, 1, 0, 1,  8,    9,    0, 0,    0,    2'b10);
    tbl[11] = mk(1, 1, 0, 1,  8,    10,   0, 0,    0,    2'b10);
    tbl[12] = mk(1, 1, 0, 0,  8,    11,   0, 0,    0,    2'b10);
    tbl[13] = mk(1, 1, 0, 0,  8,    12,   0, 0,    0,    2'b01);
    tbl[14] = mk(1, 0, 1, 0,  30,   0,    0, 0,    0,    2'b01);
    tbl[15] = mk(0, 1, 0, 0,  0,    31,   0, 0,    0,    2'b10);
    tbl[16] = mk(1, 1, 0, 0,  32,   33,   0, 0,    0,    2'b01);
    tbl[17] = mk(1, 0, 0, 0,  7,    0,    1, 7,    10,   2'b01);
    tbl[18] = mk(1, 0, 0, 0,  7,    0,    0, 0,    0,    2'b01);
    for (int i = 0; i < 19; i++) cycle(tbl[i]);

    // Two full bursts to requester 0; the second proves the counter cleared
    cycle(mk(0, 1, 0, 0, 0, 40, 0, 0, 0, 2'b10));
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < int'(BURST_MAX); k++)
        cycle(mk(1, 1, 1, 0, 100 + k, 200, 0, 0, 0, 2'b01));
      cycle(mk(1, 1, 1, 0, 150, 201 + rep, 0, 0, 0, 2'b10));
    end

    // Lone locked requester runs past BURST_MAX; the other then gets in at once
    for (int k = 0; k < int'(BURST_MAX) + 10; k++)
      cycle(mk(1, 0, 1, 0, 300 + k, 0, 0, 0, 0, 2'b01));
    cycle(mk(1, 1, 1, 0, 400, 401, 0, 0, 0, 2'b10));

    // Reset lands mid-burst while a grant is in flight
    cycle(mk(1, 1, 1, 0, 500, 501, 0, 0, 0, 2'b01));
    cycle(mk(1, 1, 1, 0, 502, 503, 0, 0, 0, 2'b01));
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("midreset");
    sb.delete();
    rd_req0 = 1'b0; rd_req1 = 1'b0; rd_lock0 = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    exp_raddr = '0;
    sb.push_back(none);
    cycle(mk(0, 1, 0, 0, 0, 60, 0, 0, 0, 2'b10));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    @(negedge Clk);
    check_resp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
